id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage that directly feeds the 64-bit EX-stage ALU (inputs a, b, ALUOp, Shift).
- Registers decoded operands and control on each clock.
- Resolves EX/MEM and MEM/WB data forwarding combinationally on the registered operands to drive the ALU inputs.
- Detects load-use hazards and inserts one bubble; supports an external hold and a branch/exception flush.

Parameters:
- XLEN, 64, datapath width; ALU operands, immediate and forwarded data.
- REGW, 5, register index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- hold  in  1  external stall (e.g. memory busy); freezes stage contents
- flush  in  1  squash stage contents (branch taken / exception)
- id_valid  in  1  ID-stage instruction valid
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REGW  register indices
- id_alu_op  in  4  ALU operation code: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111
- id_shift  in  1  with ADD code selects shift-left by b[4:0]
- id_alu_src  in  1  1 = b from immediate
- id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  control bits
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd  in  REGW  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd  in  REGW  MEM/WB destination
- memwb_data  in  XLEN  MEM/WB writeback data
- alu_a, alu_b  out  XLEN  ALU operands (combinational from registered state plus forwarding)
- alu_op  out  4  registered ALU operation code
- alu_shift  out  1  registered shift select
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_rd  out  REGW  registered destination
- ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered control
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID when high

Behaviour:
- Registered fields: valid, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_op, shift, alu_src, mem_read, mem_write, reg_write, mem_to_reg.
- Reset value of every registered field is 0. After reset, alu_a = alu_b = ex_store_data = 0, alu_op = 0000, and all control outputs are 0.
- uses_rs2 = ~id_alu_src | id_mem_write.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- Update priority at the rising edge, highest first:
  - reset: clear all fields.
  - flush: clear all fields (bubble).
  - hold: keep all fields.
  - load_use_stall: clear all fields (bubble). The upstream holds ID, so the instruction re-presents next cycle.
  - otherwise: capture all id_* inputs. ex_valid = id_valid. If id_valid = 0, control bits are captured as 0.
- Flush overrides hold. load_use_stall is still driven combinationally during hold; the upstream ORs it with hold.
- Forwarding of rs1, producing alu_a:
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rs1, select exmem_result.
  - Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == ex_rs1, select memwb_data.
  - Else select registered rs1_data.
  - EX/MEM has priority over MEM/WB.
- Forwarding of rs2, producing fwd2: same rule applied to ex_rs2.
- alu_b = alu_src ? imm : fwd2.
- ex_store_data = fwd2 always.
- Register x0 never forwards and never triggers a stall.
- Register-file write-through in the same cycle is outside this block.
- Latency: one cycle from ID inputs to registered outputs; zero cycles from forwarding inputs to alu_a/alu_b.
- A stall bubble costs exactly one cycle. A second consecutive stall occurs only if the hazard persists, which cannot happen because the bubble clears ex_mem_read.

Test Plan:
- Reset then idle: assert reset 2 cycles -> all outputs 0, load_use_stall = 0, alu_op = 0000.
- Plain ADD: capture id_rs1_data = 5, id_rs2_data = 7, alu_op = 0010, alu_src = 0 with no forwarding match -> next cycle alu_a = 5, alu_b = 7, ex_valid = 1.
- Forward priority: ex_rs1 = 3, exmem_rd = 3 with result 0x11, memwb_rd = 3 with data 0x22 -> alu_a = 0x11. Drop exmem_reg_write -> alu_a = 0x22. Set rd = 0 on both -> alu_a = registered rs1_data.
- Load-use: EX holds ld x4 (mem_read = 1, rd = 4), ID presents add x5, x4, x1 -> load_use_stall = 1 and next cycle ex_valid = 0 with all control 0. With ID held, the following edge captures the add and memwb forwarding supplies x4.
- Store rs2 check: EX load rd = 6, ID sd with rs2 = 6, alu_src = 1 -> load_use_stall = 1. Same case with an addi using rs2 field = 6 -> stall = 0.
- Hold vs flush: hold = 1 for 3 cycles -> outputs unchanged. Assert hold and flush together -> bubble captured, ex_valid = 0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the 64-bit EX ALU.
// Handles EX/MEM and MEM/WB forwarding, load-use bubbles, hold and flush.
module id_ex_operand_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned REGW = 5
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [REGW-1:0] id_rs1_i,
  input  logic [REGW-1:0] id_rs2_i,
  input  logic [REGW-1:0] id_rd_i,
  input  logic [3:0]      id_alu_op_i,
  input  logic            id_shift_i,
  input  logic            id_alu_src_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_to_reg_i,
  input  logic            exmem_reg_write_i,
  input  logic [REGW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [REGW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_shift_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [REGW-1:0] ex_rd_o,
  output logic            ex_valid_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_to_reg_o,
  output logic            load_use_stall_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [REGW-1:0] rs1_q, rs1_d;
  logic [REGW-1:0] rs2_q, rs2_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            shift_q, shift_d;
  logic            alu_src_q, alu_src_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;

  logic            uses_rs2;
  logic            load_use_stall;
  logic            bubble;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  // A store reads rs2 as data even though b comes from the immediate.
  assign uses_rs2 = ~id_alu_src_i | id_mem_write_i;

  assign load_use_stall = id_valid_i & valid_q & mem_read_q & (rd_q != '0) &
                          ((rd_q == id_rs1_i) | (uses_rs2 & (rd_q == id_rs2_i)));

  assign bubble = flush_i | (~hold_i & load_use_stall);

  always_comb begin
    valid_d      = valid_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    alu_op_d     = alu_op_q;
    shift_d      = shift_q;
    alu_src_d    = alu_src_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;

    if (bubble) begin
      valid_d      = 1'b0;
      rs1_data_d   = '0;
      rs2_data_d   = '0;
      imm_d        = '0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
      alu_op_d     = '0;
      shift_d      = 1'b0;
      alu_src_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!hold_i) begin
      valid_d      = id_valid_i;
      rs1_data_d   = id_rs1_data_i;
      rs2_data_d   = id_rs2_data_i;
      imm_d        = id_imm_i;
      rs1_d        = id_rs1_i;
      rs2_d        = id_rs2_i;
      rd_d         = id_rd_i;
      alu_op_d     = id_alu_op_i;
      shift_d      = id_shift_i;
      alu_src_d    = id_alu_src_i;
      // Invalid slots must not carry side-effecting control into EX.
      mem_read_d   = id_valid_i & id_mem_read_i;
      mem_write_d  = id_valid_i & id_mem_write_i;
      reg_write_d  = id_valid_i & id_reg_write_i;
      mem_to_reg_d = id_valid_i & id_mem_to_reg_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q      <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_op_q     <= '0;
      shift_q      <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      alu_op_q     <= alu_op_d;
      shift_q      <= shift_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  // The younger producer (EX/MEM) wins; x0 never forwards.
  always_comb begin
    fwd1 = rs1_data_q;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_q)) begin
      fwd1 = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_q)) begin
      fwd1 = memwb_data_i;
    end
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_q)) begin
      fwd2 = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_q)) begin
      fwd2 = memwb_data_i;
    end
  end

  assign alu_a_o          = fwd1;
  assign alu_b_o          = alu_src_q ? imm_q : fwd2;
  assign ex_store_data_o  = fwd2;
  assign alu_op_o         = alu_op_q;
  assign alu_shift_o      = shift_q;
  assign ex_rd_o          = rd_q;
  assign ex_valid_o       = valid_q;
  assign ex_mem_read_o    = mem_read_q;
  assign ex_mem_write_o   = mem_write_q;
  assign ex_reg_write_o   = reg_write_q;
  assign ex_mem_to_reg_o  = mem_to_reg_q;
  assign load_use_stall_o = load_use_stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        reset_i, hold_i, flush_i;
  logic        id_valid_i;
  logic [63:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [3:0]  id_alu_op_i;
  logic        id_shift_i, id_alu_src_i;
  logic        id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [63:0] exmem_result_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [63:0] memwb_data_i;
  logic [63:0] alu_a_o, alu_b_o, ex_store_data_o;
  logic [3:0]  alu_op_o;
  logic        alu_shift_o;
  logic [4:0]  ex_rd_o;
  logic        ex_valid_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o;
  logic        load_use_stall_o;
  logic [3:0]  ctrl;

  int n_cmp = 0;
  int n_err = 0;

  assign ctrl = {ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o};

  id_ex_operand_stage #(.XLEN(64), .REGW(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_alu_op_i(id_alu_op_i), .id_shift_i(id_shift_i), .id_alu_src_i(id_alu_src_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o), .alu_shift_o(alu_shift_o),
    .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .load_use_stall_o(load_use_stall_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [3:0] op, input logic sh,
                        input logic src, input logic mr, input logic mw, input logic rw,
                        input logic m2r);
    id_valid_i = v; id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
    id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd; id_alu_op_i = op; id_shift_i = sh;
    id_alu_src_i = src; id_mem_read_i = mr; id_mem_write_i = mw;
    id_reg_write_i = rw; id_mem_to_reg_i = m2r;
  endtask

  task automatic fwd_clear();
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
  endtask

  task automatic test_reset();
    hold_i = 0; flush_i = 0; fwd_clear();
    id_set(1, 64'h1234, 64'h5678, 64'h9a, 5'd3, 5'd4, 5'd5, 4'b0110, 1, 1, 1, 1, 1, 1);
    reset_i = 1;
    step(); step();
    reset_i = 0;
    id_set(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (alu_a_o !== 64'h0) begin n_err++; $display("FAIL reset_alu_a got %0h exp 0", alu_a_o); end
    n_cmp++; if (alu_b_o !== 64'h0) begin n_err++; $display("FAIL reset_alu_b got %0h exp 0", alu_b_o); end
    n_cmp++; if (ex_store_data_o !== 64'h0) begin n_err++; $display("FAIL reset_store got %0h exp 0", ex_store_data_o); end
    n_cmp++; if (alu_op_o !== 4'b0000) begin n_err++; $display("FAIL reset_alu_op got %b exp 0000", alu_op_o); end
    n_cmp++; if ({ex_valid_o, ctrl, alu_shift_o} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl got %b exp 000000", {ex_valid_o, ctrl, alu_shift_o}); end
    n_cmp++; if (ex_rd_o !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0d exp 0", ex_rd_o); end
    n_cmp++; if (load_use_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", load_use_stall_o); end
  endtask

  task automatic test_plain_add();
    id_set(1, 64'd5, 64'd7, 64'h0, 5'd1, 5'd2, 5'd3, 4'b0010, 1, 0, 0, 0, 1, 0);
    step();
    n_cmp++; if (alu_a_o !== 64'd5) begin n_err++; $display("FAIL add_alu_a got %0h exp 5", alu_a_o); end
    n_cmp++; if (alu_b_o !== 64'd7) begin n_err++; $display("FAIL add_alu_b got %0h exp 7", alu_b_o); end
    n_cmp++; if (ex_store_data_o !== 64'd7) begin n_err++; $display("FAIL add_store got %0h exp 7", ex_store_data_o); end
    n_cmp++; if (alu_op_o !== 4'b0010) begin n_err++; $display("FAIL add_op got %b exp 0010", alu_op_o); end
    n_cmp++; if (alu_shift_o !== 1'b1) begin n_err++; $display("FAIL add_shift got %b exp 1", alu_shift_o); end
    n_cmp++; if ({ex_valid_o, ctrl} !== 5'b1_0010) begin n_err++; $display("FAIL add_ctrl got %b exp 10010", {ex_valid_o, ctrl}); end
    n_cmp++; if (ex_rd_o !== 5'd3) begin n_err++; $display("FAIL add_rd got %0d exp 3", ex_rd_o); end
    // Invalid slot: data captured, control forced low.
    id_set(0, 64'h44, 64'h66, 64'h0, 5'd7, 5'd8, 5'd9, 4'b0001, 0, 0, 1, 1, 1, 1);
    step();
    n_cmp++; if ({ex_valid_o, ctrl} !== 5'b0) begin n_err++; $display("FAIL invalid_ctrl got %b exp 00000", {ex_valid_o, ctrl}); end
    n_cmp++; if (alu_a_o !== 64'h44) begin n_err++; $display("FAIL invalid_alu_a got %0h exp 44", alu_a_o); end
  endtask

  task automatic test_forward_priority();
    id_set(1, 64'h33, 64'h55, 64'h77, 5'd3, 5'd9, 5'd7, 4'b0010, 0, 0, 0, 0, 1, 0);
    step();
    id_set(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    exmem_reg_write_i = 1; exmem_rd_i = 3; exmem_result_i = 64'h11;
    memwb_reg_write_i = 1; memwb_rd_i = 3; memwb_data_i = 64'h22;
    #1;
    n_cmp++; if (alu_a_o !== 64'h11) begin n_err++; $display("FAIL fwd_exmem_prio got %0h exp 11", alu_a_o); end
    n_cmp++; if (alu_b_o !== 64'h55) begin n_err++; $display("FAIL fwd_b_nomatch got %0h exp 55", alu_b_o); end
    exmem_reg_write_i = 0; #1;
    n_cmp++; if (alu_a_o !== 64'h22) begin n_err++; $display("FAIL fwd_memwb got %0h exp 22", alu_a_o); end
    exmem_reg_write_i = 1; exmem_rd_i = 0; memwb_rd_i = 0; #1;
    n_cmp++; if (alu_a_o !== 64'h33) begin n_err++; $display("FAIL fwd_x0 got %0h exp 33", alu_a_o); end
    exmem_rd_i = 9; exmem_result_i = 64'h99; memwb_rd_i = 9; #1;
    n_cmp++; if (alu_b_o !== 64'h99) begin n_err++; $display("FAIL fwd2_exmem got %0h exp 99", alu_b_o); end
    n_cmp++; if (ex_store_data_o !== 64'h99) begin n_err++; $display("FAIL fwd2_store got %0h exp 99", ex_store_data_o); end
    exmem_reg_write_i = 0; #1;
    n_cmp++; if (alu_b_o !== 64'h22) begin n_err++; $display("FAIL fwd2_memwb got %0h exp 22", alu_b_o); end
    // Immediate operand bypasses forwarding; store data still forwards.
    id_set(1, 64'h33, 64'h55, 64'h77, 5'd3, 5'd9, 5'd7, 4'b0010, 0, 1, 0, 1, 0, 0);
    step();
    n_cmp++; if (alu_b_o !== 64'h77) begin n_err++; $display("FAIL imm_alu_b got %0h exp 77", alu_b_o); end
    n_cmp++; if (ex_store_data_o !== 64'h22) begin n_err++; $display("FAIL imm_store got %0h exp 22", ex_store_data_o); end
    fwd_clear();
  endtask

  task automatic test_load_use();
    id_set(1, 64'h100, 64'h0, 64'h8, 5'd2, 5'd0, 5'd4, 4'b0010, 0, 1, 1, 0, 1, 1);
    step();
    id_set(1, 64'h99, 64'h3, 64'h0, 5'd4, 5'd1, 5'd5, 4'b0010, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (load_use_stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", load_use_stall_o); end
    step();
    n_cmp++; if ({ex_valid_o, ctrl} !== 5'b0) begin n_err++; $display("FAIL lu_bubble got %b exp 00000", {ex_valid_o, ctrl}); end
    n_cmp++; if (ex_rd_o !== 5'd0) begin n_err++; $display("FAIL lu_bubble_rd got %0d exp 0", ex_rd_o); end
    n_cmp++; if (load_use_stall_o !== 1'b0) begin n_err++; $display("FAIL lu_restall got %b exp 0", load_use_stall_o); end
    memwb_reg_write_i = 1; memwb_rd_i = 4; memwb_data_i = 64'habc;
    step();
    n_cmp++; if (alu_a_o !== 64'habc) begin n_err++; $display("FAIL lu_fwd_a got %0h exp abc", alu_a_o); end
    n_cmp++; if (alu_b_o !== 64'h3) begin n_err++; $display("FAIL lu_alu_b got %0h exp 3", alu_b_o); end
    n_cmp++; if ({ex_valid_o, ex_rd_o} !== {1'b1, 5'd5}) begin n_err++; $display("FAIL lu_capture got %b/%0d exp 1/5", ex_valid_o, ex_rd_o); end
    fwd_clear();
  endtask

  task automatic test_store_rs2();
    id_set(1, 64'h0, 64'h0, 64'h10, 5'd1, 5'd0, 5'd6, 4'b0010, 0, 1, 1, 0, 1, 1);
    step();
    id_set(1, 64'h0, 64'h0, 64'h8, 5'd2, 5'd6, 5'd0, 4'b0010, 0, 1, 0, 1, 0, 0);
    #1;
    n_cmp++; if (load_use_stall_o !== 1'b1) begin n_err++; $display("FAIL sd_stall got %b exp 1", load_use_stall_o); end
    id_set(1, 64'h0, 64'h0, 64'h8, 5'd2, 5'd6, 5'd7, 4'b0010, 0, 1, 0, 0, 1, 0);
    #1;
    n_cmp++; if (load_use_stall_o !== 1'b0) begin n_err++; $display("FAIL addi_nostall got %b exp 0", load_use_stall_o); end
    id_set(1, 64'h0, 64'h0, 64'h0, 5'd2, 5'd6, 5'd7, 4'b0010, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (load_use_stall_o !== 1'b1) begin n_err++; $display("FAIL rtype_rs2_stall got %b exp 1", load_use_stall_o); end
    id_valid_i = 0; #1;
    n_cmp++; if (load_use_stall_o !== 1'b0) begin n_err++; $display("FAIL invalid_nostall got %b exp 0", load_use_stall_o); end
    // Load into x0 never stalls.
    id_set(1, 64'h0, 64'h0, 64'h10, 5'd1, 5'd0, 5'd0, 4'b0010, 0, 1, 1, 0, 1, 1);
    step();
    id_set(1, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd7, 4'b0010, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (load_use_stall_o !== 1'b0) begin n_err++; $display("FAIL x0_nostall got %b exp 0", load_use_stall_o); end
  endtask

  task automatic test_hold_flush();
    id_set(1, 64'ha1, 64'hb2, 64'hc3, 5'd1, 5'd2, 5'd8, 4'b0110, 0, 0, 0, 0, 1, 0);
    step();
    hold_i = 1;
    id_set(1, 64'hff, 64'hee, 64'hdd, 5'd10, 5'd11, 5'd12, 4'b1100, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({alu_a_o, alu_b_o, alu_op_o, ex_rd_o, ex_valid_o, ctrl} !==
          {64'ha1, 64'hb2, 4'b0110, 5'd8, 1'b1, 4'b0010}) begin
        n_err++;
        $display("FAIL hold_keep[%0d] got a=%0h b=%0h op=%b rd=%0d v=%b ctrl=%b exp a1/b2/0110/8/1/0010",
                 i, alu_a_o, alu_b_o, alu_op_o, ex_rd_o, ex_valid_o, ctrl);
      end
    end
    flush_i = 1;
    step();
    hold_i = 0; flush_i = 0;
    n_cmp++; if ({ex_valid_o, ctrl} !== 5'b0) begin n_err++; $display("FAIL hold_flush_bubble got %b exp 00000", {ex_valid_o, ctrl}); end
    n_cmp++; if (alu_a_o !== 64'h0) begin n_err++; $display("FAIL hold_flush_alu_a got %0h exp 0", alu_a_o); end
    // Hold beats a load-use bubble, but the stall output stays live.
    id_set(1, 64'h0, 64'h0, 64'h0, 5'd1, 5'd0, 5'd4, 4'b0010, 0, 1, 1, 0, 1, 1);
    step();
    hold_i = 1;
    id_set(1, 64'h0, 64'h0, 64'h0, 5'd4, 5'd1, 5'd5, 4'b0010, 0, 0, 0, 0, 1, 0);
    #1;
    n_cmp++; if (load_use_stall_o !== 1'b1) begin n_err++; $display("FAIL hold_stall_live got %b exp 1", load_use_stall_o); end
    step();
    n_cmp++; if ({ex_valid_o, ex_mem_read_o, ex_rd_o} !== {1'b1, 1'b1, 5'd4}) begin n_err++; $display("FAIL hold_over_stall got %b/%b/%0d exp 1/1/4", ex_valid_o, ex_mem_read_o, ex_rd_o); end
    hold_i = 0; flush_i = 1;
    step();
    flush_i = 0;
    n_cmp++; if ({ex_valid_o, ctrl, ex_rd_o} !== 10'b0) begin n_err++; $display("FAIL flush_bubble got %b exp 0", {ex_valid_o, ctrl, ex_rd_o}); end
  endtask

  initial begin
    test_reset();
    test_plain_add();
    test_forward_priority();
    test_load_use();
    test_store_rs2();
    test_hold_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
